// File: rtl/contador_displays.sv
// MM:SS run-time counter advanced by rising edges of a slow tick, with a
// four-digit common-anode seven-segment scan driver.
module contador_displays #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        tick_in,
  input  logic        pausa,
  input  logic        clear,
  output logic [15:0] digits,
  output logic        rollover,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  logic             tick_q;
  logic             tick_pulse;
  logic [15:0]      digits_q, digits_d, digits_inc;
  logic             rollover_q, rollover_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       digit_sel;

  // tick_q resets high so a tick already high at reset release is not counted
  assign tick_pulse = tick_in & ~tick_q;

  // Ripple BCD increment with per-digit limits 9, 5, 9, 5
  always_comb begin
    digits_inc = digits_q;
    if (digits_q[3:0] != 4'd9) begin
      digits_inc[3:0] = digits_q[3:0] + 4'd1;
    end else begin
      digits_inc[3:0] = '0;
      if (digits_q[7:4] != 4'd5) begin
        digits_inc[7:4] = digits_q[7:4] + 4'd1;
      end else begin
        digits_inc[7:4] = '0;
        if (digits_q[11:8] != 4'd9) begin
          digits_inc[11:8] = digits_q[11:8] + 4'd1;
        end else begin
          digits_inc[11:8] = '0;
          if (digits_q[15:12] != 4'd5) begin
            digits_inc[15:12] = digits_q[15:12] + 4'd1;
          end else begin
            digits_inc[15:12] = '0;
          end
        end
      end
    end
  end

  always_comb begin
    digits_d   = digits_q;
    rollover_d = 1'b0;
    if (clear) begin
      digits_d = '0;
    end else if (tick_pulse && !pausa) begin
      digits_d   = digits_inc;
      rollover_d = (digits_q == 16'h5959);
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + CNT_W'(1);
    sel_d      = sel_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      sel_d      = sel_q + 2'd1;
    end
  end

  always_comb begin
    case (sel_q)
      2'd0:    digit_sel = digits_q[3:0];
      2'd1:    digit_sel = digits_q[7:4];
      2'd2:    digit_sel = digits_q[11:8];
      default: digit_sel = digits_q[15:12];
    endcase
  end

  // Segment order {g,f,e,d,c,b,a}, active low; non-BCD codes blank
  always_comb begin
    case (digit_sel)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase
  end

  always_comb begin
    an_d = ~(4'b0001 << sel_q);
    dp_d = ~((sel_q == 2'd2) && tick_q);
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      tick_q     <= 1'b1;
      digits_q   <= '0;
      rollover_q <= 1'b0;
      scan_cnt_q <= '0;
      sel_q      <= '0;
      an_q       <= '1;
      seg_q      <= '1;
      dp_q       <= 1'b1;
    end else begin
      tick_q     <= tick_in;
      digits_q   <= digits_d;
      rollover_q <= rollover_d;
      scan_cnt_q <= scan_cnt_d;
      sel_q      <= sel_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign digits   = digits_q;
  assign rollover = rollover_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;

endmodule

// File: doc/contador_displays.md
# contador_displays

Time-of-run counter and display driver sitting directly downstream of the `reloj_displays` clock divider. It takes the divider's slow square wave (`clock_out`, 50 % duty) as a level input and detects its rising edges. Each rising edge advances a four-digit BCD MM:SS count. The block time-multiplexes the count onto four common-anode seven-segment displays, with pause and clear controls. All logic runs on the single fast board clock.

## Interface

**Parameters**
- `SCAN_DIV`, default 100000: `clock_in` cycles each digit stays selected before the scan advances. Must be ≥ 2.

**Ports**
- `clock_in` — in, 1: board clock; everything is clocked on its rising edge.
- `reset_n` — in, 1: synchronous, active-low reset.
- `tick_in` — in, 1: slow square wave from `reloj_displays.clock_out`, produced in the `clock_in` domain.
- `pausa` — in, 1: when high, tick edges are ignored and the count holds.
- `clear` — in, 1: synchronous zero of the count.
- `digits` — out, 16: `{min_tens, min_units, sec_tens, sec_units}`, 4-bit BCD each.
- `rollover` — out, 1: one-cycle pulse on the 59:59 → 00:00 wrap.
- `an` — out, 4: active-low anode enables; bit 0 selects `sec_units`.
- `seg` — out, 7: active-low segments, bit order `{g,f,e,d,c,b,a}`.
- `dp` — out, 1: active-low decimal point.

## Operation

**Tick edge detection**
- Register `tick_q` <= `tick_in` every cycle.
- `tick_pulse` = `tick_in & ~tick_q` (combinational, one cycle wide).
- `tick_q` resets to 1, so a `tick_in` already high at reset release never produces a count.

**Count**
- Four BCD digits: `sec_units` 0–9, `sec_tens` 0–5, `min_units` 0–9, `min_tens` 0–5.
- Priority, highest first:
  1. `reset_n` = 0
  2. `clear` = 1
  3. `tick_pulse & ~pausa`
  4. hold
- An increment is a ripple BCD add of 1: each digit wraps to 0 and carries into the next at its limit (9, 5, 9, 5).
- 59:59 + 1 → 00:00. `rollover` is 1 for exactly the cycle following that edge, otherwise 0.
- A pulse that arrives while `pausa`, `clear` or reset is active is discarded, not queued.
- `tick_q` keeps tracking while paused, so releasing `pausa` with `tick_in` high produces no spurious count.

**Display scan**
- `scan_cnt` runs 0 … `SCAN_DIV`-1.
- At terminal count it returns to 0 and `sel` (2 bits) advances 0→1→2→3→0.
- Registered outputs are updated every cycle from the current `sel`:
  - `an` = ~(1 << `sel`).
  - `seg` = active-low decode of the selected digit: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - `dp` = 0 only when `sel` = 2 and `tick_q` = 1 (blinking minute/second separator); otherwise 1.
- Non-BCD codes cannot occur; if one did, the decoder drives blank (1111111).

## Timing

**Reset values** (applied at the first rising edge with `reset_n` = 0):
- `digits` = 0, `rollover` = 0
- `an` = 1111, `seg` = 1111111, `dp` = 1
- `scan_cnt` = 0, `sel` = 0, `tick_q` = 1

**Latencies**
- `tick_in` rise to `digits` change: 1 edge. The edge that samples `tick_in` = 1 with `tick_q` = 0 updates `digits`.
- `sel` change to `an`/`seg`/`dp` change: 1 cycle. The first edge after reset release drives `an` = 1110 and `seg` = 1000000.
- `clear` to `digits` = 0: 1 edge. `clear` does not disturb the scan.
- Each digit is selected for exactly `SCAN_DIV` cycles. The full refresh period is 4·`SCAN_DIV` cycles.

**Boundary conditions**
- Reset asserted mid-count or mid-scan: all state returns to reset values at that edge; no partial update.
- `clear` together with `tick_pulse`: result is 00:00, and `rollover` stays 0 even from 59:59.
- `pausa` together with `tick_pulse` at 59:59: count holds at 59:59, and `rollover` stays 0.

## Test plan
- **Reset and power-up:** hold `reset_n` = 0 for 3 cycles with `tick_in` = 1, then release. Required: `digits` = 0x0000. No count on release, even though `tick_in` is already high.
- **Basic count:** apply 10 rising edges of `tick_in` (high 5 cycles / low 5 cycles). Required: `digits` = 0x0010, each step exactly 1 cycle after the `tick_in` rise.
- **Wrap:** preload to 0x5959 by counting, then apply one edge. Required: `digits` = 0x0000 and `rollover` high for exactly one cycle. Also confirm 0x0059 → 0x0100.
- **Pause:** set `pausa` = 1 across 3 edges, then release while `tick_in` is high. Required: `digits` unchanged, and no increment on release.
- **Clear priority:** assert `clear` in the same cycle as `tick_pulse` at 0x5959. Required: `digits` = 0x0000 and `rollover` = 0.
- **Scan** (`SCAN_DIV` = 4, `digits` = 0x1234):
  - `an` cycles 1110 → 1101 → 1011 → 0111, each held 4 cycles.
  - `seg` = 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1) respectively.
  - `dp` = 0 only during `an` = 1011 while `tick_q` = 1.
